cpu_mem_responder: RTL and testbench

//  Memory-side responder for the 8-bit CPU core. Drives inst for the CPU's address and

---
 rtl/cpu_mem_responder.sv | 128 ++++++++++++
 tb/tb_cpu_mem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 8-bit CPU: instruction memory loaded while the CPU is held in
// reset, then instruction fetch and store absorption into a data RAM once released into RUN.
module cpu_mem_responder #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_done,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] out_data,
  input  logic              store,
  output logic [DATA_W-1:0] inst,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [7:0]        store_count,
  output logic              prog_err
);

  localparam int unsigned CntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    StLoad,
    StRelease,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] dbg_data_q;
  logic              cpu_reset_q, cpu_reset_d;
  logic [7:0]        store_count_q, store_count_d;
  logic              prog_err_q, prog_err_d;
  logic              imem_we, dmem_we;

  logic [DATA_W-1:0] imem [DEPTH];
  logic [DATA_W-1:0] dmem [DEPTH];

  // Next-state, write enables and fetch mux.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    inst_d        = '0;
    store_count_d = store_count_q;
    prog_err_d    = prog_err_q;
    imem_we       = 1'b0;
    dmem_we       = 1'b0;

    unique case (state_q)
      StLoad: begin
        imem_we = prog_we;
        if (prog_done) begin
          state_d = StRelease;
          cnt_d   = '0;
        end
      end
      StRelease: begin
        if (cnt_q == CntLast) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        inst_d  = imem[address];
        dmem_we = store;
        if (store && (store_count_q != 8'hFF)) begin
          store_count_d = store_count_q + 8'd1;
        end
      end
      default: begin
        state_d = StLoad;
      end
    endcase

    if (prog_we && (state_q != StLoad)) begin
      prog_err_d = 1'b1;
    end

    // Registered so that it falls exactly on the edge that enters RUN.
    cpu_reset_d = (state_d != StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StLoad;
      cnt_q         <= '0;
      inst_q        <= '0;
      cpu_reset_q   <= 1'b1;
      dbg_data_q    <= '0;
      store_count_q <= '0;
      prog_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      inst_q        <= inst_d;
      cpu_reset_q   <= cpu_reset_d;
      dbg_data_q    <= dmem[dbg_addr];
      store_count_q <= store_count_d;
      prog_err_q    <= prog_err_d;
    end
  end

  // Arrays carry no reset; contents survive a reset of the control logic.
  always_ff @(posedge clk) begin
    if (!reset && imem_we) begin
      imem[prog_addr] <= prog_data;
    end
    if (!reset && dmem_we) begin
      dmem[address] <= out_data;
    end
  end

  assign inst        = inst_q;
  assign cpu_reset   = cpu_reset_q;
  assign dbg_data    = dbg_data_q;
  assign store_count = store_count_q;
  assign prog_err    = prog_err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed, table-driven bench for cpu_mem_responder: load, release timing, fetch, stores,
// read-before-write readback, counter saturation, stray program writes and mid-RUN reset.
module tb_cpu_mem_responder;

  logic       clk;
  logic       reset;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic       prog_done;
  logic [7:0] address;
  logic [7:0] out_data;
  logic       store;
  logic [7:0] inst;
  logic       cpu_reset;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [7:0] store_count;
  logic       prog_err;

  int errors = 0;
  int checks = 0;

  cpu_mem_responder #(
    .ADDR_W(8),
    .DATA_W(8),
    .DEPTH(256),
    .RST_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_done(prog_done),
    .address(address),
    .out_data(out_data),
    .store(store),
    .inst(inst),
    .cpu_reset(cpu_reset),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .store_count(store_count),
    .prog_err(prog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic       st;
    logic [7:0] od;
    logic [7:0] dbg;
    logic [7:0] e_inst;
    logic       chk_dbg;
    logic [7:0] e_dbg;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_done = 1'b0;
    address   = '0;
    out_data  = '0;
    store     = 1'b0;
    dbg_addr  = '0;

    //              addr   st    od     dbg    inst   chk   dbg    cnt
    vecs[0] = '{8'h02, 1'b0, 8'h00, 8'h00, 8'h42, 1'b0, 8'h00, 8'd0};
    vecs[1] = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0, 8'h00, 8'd0};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h81, 1'b0, 8'h00, 8'd0};
    vecs[3] = '{8'h10, 1'b1, 8'h33, 8'h01, 8'h5A, 1'b0, 8'h00, 8'd1};
    vecs[4] = '{8'h11, 1'b1, 8'h44, 8'h10, 8'h6B, 1'b1, 8'h33, 8'd2};
    vecs[5] = '{8'h10, 1'b1, 8'hA5, 8'h10, 8'h5A, 1'b1, 8'h33, 8'd3};
    vecs[6] = '{8'h03, 1'b0, 8'h00, 8'h10, 8'h10, 1'b1, 8'hA5, 8'd3};
    vecs[7] = '{8'h01, 1'b0, 8'h00, 8'h11, 8'h05, 1'b1, 8'h44, 8'd3};
    vecs[8] = '{8'h11, 1'b1, 8'h55, 8'h11, 8'h6B, 1'b1, 8'h44, 8'd4};
    vecs[9] = '{8'h02, 1'b0, 8'h00, 8'h11, 8'h42, 1'b1, 8'h55, 8'd4};

    step();
    step();
    reset = 1'b0;
    chk("reset_inst", inst, 8'h00);
    chk("reset_cpu_reset", cpu_reset, 1'b1);
    chk("reset_dbg_data", dbg_data, 8'h00);
    chk("reset_store_count", store_count, 8'd0);
    chk("reset_prog_err", prog_err, 1'b0);

    // LOAD: stores and fetch are ignored here.
    load(8'h00, 8'h81);
    load(8'h01, 8'h05);
    load(8'h02, 8'h42);
    load(8'h03, 8'h10);
    load(8'h10, 8'h5A);
    address = 8'h02;
    load(8'h11, 8'h6B);
    chk("load_inst_held", inst, 8'h00);
    chk("load_cpu_reset", cpu_reset, 1'b1);
    chk("load_no_err", prog_err, 1'b0);

    // Final write coincides with prog_done: write lands, then FSM advances.
    prog_we   = 1'b1;
    prog_addr = 8'hFF;
    prog_data = 8'h3C;
    prog_done = 1'b1;
    step();
    prog_we   = 1'b0;
    prog_done = 1'b0;
    chk("release_c1_cpu_reset", cpu_reset, 1'b1);
    step();
    chk("release_c2_cpu_reset", cpu_reset, 1'b1);
    chk("release_inst", inst, 8'h00);
    step();
    chk("run_cpu_reset", cpu_reset, 1'b0);
    chk("run_entry_inst", inst, 8'h00);

    for (int i = 0; i < 10; i++) begin
      address  = vecs[i].addr;
      store    = vecs[i].st;
      out_data = vecs[i].od;
      dbg_addr = vecs[i].dbg;
      step();
      chk($sformatf("vec%0d_inst", i), inst, vecs[i].e_inst);
      if (vecs[i].chk_dbg) chk($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].e_dbg);
      chk($sformatf("vec%0d_count", i), store_count, vecs[i].e_cnt);
    end
    store = 1'b0;

    // Saturation: 4 stores so far, 300 more.
    address  = 8'h80;
    dbg_addr = 8'h80;
    for (int i = 0; i < 300; i++) begin
      store    = 1'b1;
      out_data = i[7:0];
      step();
      if (i == 249) chk("sat_count_254", store_count, 8'd254);
      if (i == 250) chk("sat_count_255", store_count, 8'd255);
    end
    store = 1'b0;
    step();
    chk("sat_count_hold", store_count, 8'd255);
    chk("sat_last_data", dbg_data, 8'd43);  // 299 mod 256

    // prog_done and prog_we in RUN.
    prog_done = 1'b1;
    step();
    prog_done = 1'b0;
    chk("run_prog_done_ignored", cpu_reset, 1'b0);
    prog_we   = 1'b1;
    prog_addr = 8'h00;
    prog_data = 8'hFF;
    address   = 8'h00;
    step();
    prog_we = 1'b0;
    chk("run_prog_err_set", prog_err, 1'b1);
    step();
    chk("run_imem0_kept", inst, 8'h81);
    step();
    step();
    chk("run_prog_err_sticky", prog_err, 1'b1);

    // Mid-RUN reset.
    reset    = 1'b1;
    dbg_addr = 8'h10;
    step();
    reset = 1'b0;
    chk("midrst_cpu_reset", cpu_reset, 1'b1);
    chk("midrst_inst", inst, 8'h00);
    chk("midrst_count", store_count, 8'd0);
    chk("midrst_prog_err", prog_err, 1'b0);
    chk("midrst_dbg", dbg_data, 8'h00);

    // Stores in LOAD and RELEASE must not touch dmem.
    store    = 1'b1;
    address  = 8'h10;
    out_data = 8'h00;
    step();
    chk("load2_dbg", dbg_data, 8'hA5);
    store     = 1'b0;
    prog_done = 1'b1;
    step();
    prog_done = 1'b0;
    store     = 1'b1;
    step();
    step();
    store = 1'b0;
    chk("rel2_to_run", cpu_reset, 1'b0);
    chk("rel2_count", store_count, 8'd0);
    address = 8'h00;
    step();
    chk("rel2_dmem_kept", dbg_data, 8'hA5);
    chk("rel2_imem0", inst, 8'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
